cdpga_bx_node: RTL and testbench
================================

# cdpga_bx_node

Half-duplex serial node for the CDPGA-B board. It receives addressed frames on a single RS-485-style line, checks each frame's CRC, and echoes any valid unicast frame back to the sender. The block sits directly behind the board's transceiver pins (`rx`, `tx`, `tx_en`) and serves as the board's minimal bus-reachable endpoint and loopback self-test.

## Interface
- `DIV`, default 434: clock cycles per bit (115200 baud at 50 MHz); minimum 8.
- `ADDR`, default 8'hFE: this node's address.
- `MAX_LEN`, default 16: maximum payload bytes buffered.
- `clk_i`  input  1  single system clock; all logic on rising edge.
- `reset_n_i`  input  1  asynchronous, active-low reset; tie high when unused.
- `rx`  input  1  serial receive line, idle high, asynchronous to `clk_i`.
- `tx`  output  1  serial transmit data, idle high.
- `tx_en`  output  1  transceiver driver enable, active high.

## Operation
- **Line format:** UART 8N1, LSB first.
- **Frame layout:** `src`, `dst`, `len`, `len` data bytes, CRC low byte, CRC high byte.
- **CRC:** CRC-16/MODBUS over `src..data`.
  - Initial value 16'hFFFF, reflected polynomial 16'hA001.
  - Updated one byte per cycle; no final XOR.
- **RX input:** `rx` passes through a 2-flop synchronizer.
- **Byte reception:**
  - A falling edge starts a byte.
  - The start bit is re-sampled at DIV/2; if high, the edge is treated as a glitch and ignored.
  - Data bits are sampled at DIV/2 plus k·DIV.
  - A stop bit sampled low is a framing error: discard the current frame and return to idle.
- **Inter-byte timeout:** a gap longer than 10·DIV cycles between bytes inside a frame discards the partial frame.
- **Frame acceptance:** the frame is accepted only when all of the following hold:
  - CRC matches.
  - `len` ≤ MAX_LEN.
  - `dst` == ADDR or `dst` == 8'hFF.
- **Frames that are not accepted:**
  - Frames with `len` > MAX_LEN are still clocked through to their end but are dropped.
  - Broadcast frames (8'hFF) are accepted but never answered.
- **Reply:** for an accepted unicast frame, transmit `src`=ADDR, `dst`=original `src`, the same `len` and data, and a freshly computed CRC.
- **State machine:** RX_IDLE → RX_FRAME → (accept) TURN → TX → RX_IDLE.
  - Any error returns to RX_IDLE.
- **Half-duplex rule:** while in TURN or TX, `rx` is ignored; bytes arriving then are lost.

## Timing
- **Reset values:** `tx`=1, `tx_en`=0; all state idle, buffer contents don't-care, CRC register 16'hFFFF.
- **Reset during a transfer:** asserting `reset_n_i` mid-frame or mid-reply immediately forces `tx`=1 and `tx_en`=0.
- **RX latency:** synchronizer adds 2 cycles of latency to every `rx` event.
- **Turnaround (TURN):**
  - Starts at the mid-sample of the last CRC stop bit.
  - `tx_en` rises after 2·DIV cycles.
  - The first start bit begins exactly DIV cycles after `tx_en` rises.
- **Bit timing:**
  - Each transmitted bit lasts exactly DIV cycles.
  - Bytes are back-to-back with no idle between stop bit and next start bit.
- **Release:** `tx_en` falls DIV cycles after the end of the final stop bit; `tx` stays 1 throughout.
- **Reply length:** the reply is exactly (len+5)·10 bit times long.
- **CRC corner case:** a zero-length frame (`len`=0) is valid, and its CRC follows immediately after `len`.

## Test plan
- **Reset:** hold `reset_n_i`=0 for 5 cycles, then release. Required: `tx`=1 and `tx_en`=0 throughout, and no activity for 100·DIV cycles with `rx` idle.
- **Unicast echo:** send 00 FE 02 AA 55 with a valid CRC (bench CRC model; the model must give 16'h4B37 for ASCII "123456789"). Required reply: FE 00 02 AA 55 plus correct CRC; `tx_en` rises 2·DIV after the last stop mid-sample; start bit begins DIV later.
- **Bad CRC / wrong address / broadcast:** send three frames, each of which must be ignored:
  - 00 FE 01 11 with the CRC low byte flipped;
  - 00 12 01 11 with a valid CRC;
  - 00 FF 01 11 with a valid CRC.
  
  Required: `tx_en` stays 0 for all three.
- **Zero length and max length:**
  - 01 FE 00 + CRC → reply FE 01 00 + CRC.
  - `len`=16 frame → full 16-byte echo.
  - `len`=17 frame → no reply.
- **Errors and recovery:** all three cases below must be dropped silently, and a following valid frame must be echoed correctly.
  - Framing error: stop bit forced low on byte 3.
  - Timeout: 12-bit-time gap mid-frame.
  - Glitch: 0.25-bit low pulse on `rx`.

Source files
------------

// File: rtl/cdpga_bx_node.sv
`default_nettype none
// ============================================================================
// Module      : cdpga_bx_node
// Description : Half-duplex UART node; validates addressed CRC-16/MODBUS
//               frames and echoes accepted unicast frames back to the sender.
// Revision    : 1.0 - initial release
// ============================================================================
module cdpga_bx_node #(
    parameter int         DIV     = 434,
    parameter logic [7:0] ADDR    = 8'hFE,
    parameter int         MAX_LEN = 16
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic rx,
    output logic tx,
    output logic tx_en
);
    localparam int TW = $clog2(10 * DIV + 1);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [TW-1:0] c_half_m1 = TW'(DIV / 2 - 1);
    localparam logic [TW-1:0] c_div_m1  = TW'(DIV - 1);
    localparam logic [TW-1:0] c_en_at   = TW'(2 * DIV - 1);
    localparam logic [TW-1:0] c_go_at   = TW'(3 * DIV - 1);
    localparam logic [TW-1:0] c_gap_max = TW'(10 * DIV);
    localparam logic [8:0]    c_max_len = 9'(MAX_LEN);

    typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_FRAME = 2'd1, TURN = 2'd2, TX = 2'd3} state_t;
    typedef enum logic [1:0] {B_IDLE = 2'd0, B_START = 2'd1, B_DATA = 2'd2, B_STOP = 2'd3} bstate_t;
    typedef enum logic [2:0] {P_SRC = 3'd0, P_DST = 3'd1, P_LEN = 3'd2, P_DATA = 3'd3,
                              P_CRCL = 3'd4, P_CRCH = 3'd5} pos_t;

    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    logic          rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_s3_q, rx_s3_d;
    bstate_t       bst_q, bst_d;
    logic [TW-1:0] bcnt_q, bcnt_d;
    logic [2:0]    bidx_q, bidx_d;
    logic [7:0]    shreg_q, shreg_d;
    state_t        state_q, state_d;
    pos_t          pos_q, pos_d;
    logic [7:0]    src_q, src_d, dst_q, dst_d, len_q, len_d, dcnt_q, dcnt_d;
    logic [15:0]   crc_q, crc_d;
    logic [TW-1:0] gap_q, gap_d, tcnt_q, tcnt_d;
    logic [3:0]    tbit_q, tbit_d;
    logic [8:0]    tidx_q, tidx_d;
    logic [7:0]    tbyte_q, tbyte_d;
    logic          tx_q, tx_d, tx_en_q, tx_en_d;
    logic [7:0]    mem_q [MAX_LEN];

    logic          w_byte_ok, w_frame_err, w_rx_on, w_mem_we;
    logic [15:0]   w_crc_rx;
    logic [8:0]    w_nidx, w_len9;
    logic [7:0]    w_nbyte;

    // Byte that follows tidx_q in the reply: ADDR, src, len, data, CRC lo, CRC hi
    always_comb begin
        w_len9 = {1'b0, len_q};
        w_nidx = tidx_q + 9'd1;
        if (w_nidx == 9'd1)                 w_nbyte = src_q;
        else if (w_nidx == 9'd2)            w_nbyte = len_q;
        else if (w_nidx <= w_len9 + 9'd2)   w_nbyte = mem_q[IW'(w_nidx - 9'd3)];
        else if (w_nidx == w_len9 + 9'd3)   w_nbyte = crc_q[7:0];
        else                                w_nbyte = crc_q[15:8];
    end

    always_comb begin
        rx_s1_d     = rx;
        rx_s2_d     = rx_s1_q;
        rx_s3_d     = rx_s2_q;
        bst_d       = bst_q;
        bcnt_d      = bcnt_q + TW'(1);
        bidx_d      = bidx_q;
        shreg_d     = shreg_q;
        w_byte_ok   = 1'b0;
        w_frame_err = 1'b0;
        w_rx_on     = (state_q == RX_IDLE) || (state_q == RX_FRAME);

        if (!w_rx_on) begin
            bst_d  = B_IDLE;
            bcnt_d = '0;
        end else begin
            case (bst_q)
                B_IDLE: begin
                    bcnt_d = '0;
                    if (!rx_s2_q && rx_s3_q) bst_d = B_START;
                end
                B_START: if (bcnt_q == c_half_m1) begin
                    bcnt_d = '0;
                    bidx_d = 3'd0;
                    bst_d  = rx_s2_q ? B_IDLE : B_DATA;
                end
                B_DATA: if (bcnt_q == c_div_m1) begin
                    bcnt_d  = '0;
                    shreg_d = {rx_s2_q, shreg_q[7:1]};
                    bidx_d  = bidx_q + 3'd1;
                    if (bidx_q == 3'd7) bst_d = B_STOP;
                end
                default: if (bcnt_q == c_div_m1) begin
                    bcnt_d      = '0;
                    bst_d       = B_IDLE;
                    w_byte_ok   = rx_s2_q;
                    w_frame_err = !rx_s2_q;
                end
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        dcnt_d   = dcnt_q;
        crc_d    = crc_q;
        gap_d    = '0;
        tcnt_d   = tcnt_q + TW'(1);
        tbit_d   = tbit_q;
        tidx_d   = tidx_q;
        tbyte_d  = tbyte_q;
        tx_d     = tx_q;
        tx_en_d  = tx_en_q;
        w_mem_we = 1'b0;
        w_crc_rx = crc_step(crc_q, shreg_q);

        case (state_q)
            RX_IDLE: if (w_byte_ok) begin
                src_d   = shreg_q;
                crc_d   = w_crc_rx;
                pos_d   = P_DST;
                state_d = RX_FRAME;
            end
            RX_FRAME: begin
                gap_d = (bst_q == B_IDLE) ? gap_q + TW'(1) : '0;
                if (w_frame_err || (gap_q == c_gap_max)) begin
                    state_d = RX_IDLE;
                    crc_d   = 16'hFFFF;
                end else if (w_byte_ok) begin
                    crc_d = w_crc_rx;
                    case (pos_q)
                        P_DST: begin
                            dst_d = shreg_q;
                            pos_d = P_LEN;
                        end
                        P_LEN: begin
                            len_d  = shreg_q;
                            dcnt_d = 8'd0;
                            pos_d  = (shreg_q == 8'd0) ? P_CRCL : P_DATA;
                        end
                        P_DATA: begin
                            // Oversized frames are still counted through, just not stored
                            w_mem_we = ({1'b0, len_q} <= c_max_len);
                            dcnt_d   = dcnt_q + 8'd1;
                            if (dcnt_q == len_q - 8'd1) pos_d = P_CRCL;
                        end
                        P_CRCL: pos_d = P_CRCH;
                        default: begin
                            // A valid frame plus its CRC leaves a zero residue
                            crc_d   = 16'hFFFF;
                            state_d = RX_IDLE;
                            if ((w_crc_rx == 16'h0000) && ({1'b0, len_q} <= c_max_len) &&
                                (dst_q == ADDR)) begin
                                state_d = TURN;
                                tcnt_d  = '0;
                            end
                        end
                    endcase
                end
            end
            TURN: begin
                if (tcnt_q == c_en_at) tx_en_d = 1'b1;
                if (tcnt_q == c_go_at) begin
                    state_d = TX;
                    tcnt_d  = '0;
                    tbit_d  = 4'd0;
                    tidx_d  = 9'd0;
                    tbyte_d = ADDR;
                    tx_d    = 1'b0;
                    crc_d   = crc_step(crc_q, ADDR);
                end
            end
            default: if (tcnt_q == c_div_m1) begin
                tcnt_d = '0;
                if (tbit_q == 4'd10) begin
                    tx_en_d = 1'b0;
                    tbit_d  = 4'd0;
                    state_d = RX_IDLE;
                    crc_d   = 16'hFFFF;
                end else if (tbit_q == 4'd9) begin
                    if (tidx_q == w_len9 + 9'd4) begin
                        tbit_d = 4'd10;
                        tx_d   = 1'b1;
                    end else begin
                        tidx_d  = w_nidx;
                        tbit_d  = 4'd0;
                        tbyte_d = w_nbyte;
                        tx_d    = 1'b0;
                        if (w_nidx <= w_len9 + 9'd2) crc_d = crc_step(crc_q, w_nbyte);
                    end
                end else begin
                    tbit_d = tbit_q + 4'd1;
                    tx_d   = (tbit_q == 4'd8) ? 1'b1 : tbyte_q[tbit_q[2:0]];
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
            bst_q   <= B_IDLE;
            bcnt_q  <= '0;
            bidx_q  <= 3'd0;
            shreg_q <= 8'd0;
            state_q <= RX_IDLE;
            pos_q   <= P_SRC;
            src_q   <= 8'd0;
            dst_q   <= 8'd0;
            len_q   <= 8'd0;
            dcnt_q  <= 8'd0;
            crc_q   <= 16'hFFFF;
            gap_q   <= '0;
            tcnt_q  <= '0;
            tbit_q  <= 4'd0;
            tidx_q  <= 9'd0;
            tbyte_q <= 8'd0;
            tx_q    <= 1'b1;
            tx_en_q <= 1'b0;
        end else begin
            rx_s1_q <= rx_s1_d;
            rx_s2_q <= rx_s2_d;
            rx_s3_q <= rx_s3_d;
            bst_q   <= bst_d;
            bcnt_q  <= bcnt_d;
            bidx_q  <= bidx_d;
            shreg_q <= shreg_d;
            state_q <= state_d;
            pos_q   <= pos_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            dcnt_q  <= dcnt_d;
            crc_q   <= crc_d;
            gap_q   <= gap_d;
            tcnt_q  <= tcnt_d;
            tbit_q  <= tbit_d;
            tidx_q  <= tidx_d;
            tbyte_q <= tbyte_d;
            tx_q    <= tx_d;
            tx_en_q <= tx_en_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_mem_we) mem_q[dcnt_q[IW-1:0]] <= shreg_q;
    end

    assign tx    = tx_q;
    assign tx_en = tx_en_q;

endmodule
`default_nettype wire

// File: tb/tb_cdpga_bx_node.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdpga_bx_node
// Description : Directed self-checking bench for the cdpga_bx_node echo node.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdpga_bx_node;
    localparam int         DIV     = 16;
    localparam logic [7:0] ADDR    = 8'hFE;
    localparam int         MAX_LEN = 16;

    logic clk = 1'b0;
    logic reset_n_i = 1'b0;
    logic rx = 1'b1;
    logic tx, tx_en;

    int cyc = 0;
    int n_assert = 0;
    int n_fail = 0;
    int t_last = 0;
    logic [7:0] fr [0:31];
    logic [7:0] rp [0:31];
    int fr_n = 0;
    int rp_n = 0;

    cdpga_bx_node #(.DIV(DIV), .ADDR(ADDR), .MAX_LEN(MAX_LEN)) dut (
        .clk_i    (clk),
        .reset_n_i(reset_n_i),
        .rx       (rx),
        .tx       (tx),
        .tx_en    (tx_en)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation did not finish, cycle %0d required < 90000", cyc);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bitwise reference CRC-16/MODBUS
    function automatic logic [15:0] crc_ref(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        c = c_in;
        for (int b = 0; b < 8; b++) begin
            if (c[0] ^ d[b]) c = (c >> 1) ^ 16'hA001;
            else             c = c >> 1;
        end
        return c;
    endfunction

    function automatic logic [15:0] crc_check_string();
        string s;
        logic [15:0] c;
        s = "123456789";
        c = 16'hFFFF;
        for (int i = 0; i < s.len(); i++) c = crc_ref(c, s[i]);
        return c;
    endfunction

    function automatic logic [7:0] pat(input int i);
        if (i == 0) return 8'hAA;
        if (i == 1) return 8'h55;
        return 8'(i * 29 + 3);
    endfunction

    task automatic make_frame(input logic [7:0] s, input logic [7:0] d, input int l);
        fr[0] = s;
        fr[1] = d;
        fr[2] = 8'(l);
        for (int i = 0; i < l; i++) fr[3 + i] = pat(i);
        fr_n = 3 + l;
    endtask

    task automatic add_crc(input logic flip);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < fr_n; i++) c = crc_ref(c, fr[i]);
        fr[fr_n]     = c[7:0] ^ {7'd0, flip};
        fr[fr_n + 1] = c[15:8];
        fr_n += 2;
    endtask

    task automatic make_reply();
        logic [15:0] c;
        int l;
        l = int'(fr[2]);
        rp[0] = ADDR;
        rp[1] = fr[0];
        rp[2] = fr[2];
        for (int i = 0; i < l; i++) rp[3 + i] = fr[3 + i];
        c = 16'hFFFF;
        for (int i = 0; i < l + 3; i++) c = crc_ref(c, rp[i]);
        rp[l + 3] = c[7:0];
        rp[l + 4] = c[15:8];
        rp_n = l + 5;
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v);
        t_last = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_v);
    endtask

    // bad_idx: byte sent with a low stop bit (then one idle bit);
    // gap_idx: byte followed by gap_bits idle bit times
    task automatic send_frame(input int bad_idx, input int gap_idx, input int gap_bits);
        for (int i = 0; i < fr_n; i++) begin
            send_byte(fr[i], (i == bad_idx) ? 1'b0 : 1'b1);
            if (i == bad_idx) send_bit(1'b1);
            if (i == gap_idx) repeat (gap_bits) send_bit(1'b1);
        end
    endtask

    task automatic expect_none(input string tag);
        logic seen;
        seen = 1'b0;
        repeat (20 * DIV) begin
            @(negedge clk);
            if (tx_en !== 1'b0) seen = 1'b1;
        end
        chk(tag, {31'd0, seen}, 32'd0);
    endtask

    task automatic expect_reply(input string tag);
        int t_en, t0, t_off, nominal, tgt;
        logic got;
        logic [9:0] sym;
        got = 1'b0;
        t_en = 0;
        for (int i = 0; i < 20 * DIV; i++) begin
            @(negedge clk);
            if (tx_en === 1'b1) begin
                got  = 1'b1;
                t_en = cyc;
                break;
            end
        end
        chk({tag, "_en_seen"}, {31'd0, got}, 32'd1);
        if (got) begin
            // Last stop mid-sample: rx fall + 2 sync cycles + DIV/2 + 9 bits; window covers edge-detect latency
            nominal = t_last + 2 + DIV / 2 + 9 * DIV + 2 * DIV;
            chk({tag, "_en_time"}, {31'd0, (t_en >= nominal - 2) && (t_en <= nominal + 2)}, 32'd1);
            t0 = 0;
            for (int i = 0; i < 3 * DIV; i++) begin
                @(negedge clk);
                if (tx === 1'b0) begin
                    t0 = cyc;
                    break;
                end
            end
            chk({tag, "_start_gap"}, t0 - t_en, DIV);
            for (int j = 0; j < rp_n; j++) begin
                for (int k = 0; k < 10; k++) begin
                    tgt = t0 + j * 10 * DIV + DIV / 2 + k * DIV;
                    while (cyc < tgt) @(negedge clk);
                    sym[k] = tx;
                end
                chk($sformatf("%s_byte%0d", tag, j), {22'd0, sym}, {22'd0, 1'b1, rp[j], 1'b0});
            end
            t_off = 0;
            for (int i = 0; i < 3 * DIV; i++) begin
                @(negedge clk);
                if (tx_en === 1'b0) begin
                    t_off = cyc;
                    break;
                end
            end
            chk({tag, "_release"}, t_off, t0 + rp_n * 10 * DIV + DIV);
            chk({tag, "_tx_idle"}, {31'd0, tx}, 32'd1);
        end
    endtask

    initial begin
        int bad;
        logic got;

        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_en !== 1'b0) bad++;
        end
        chk("reset_hold", bad, 0);
        reset_n_i = 1'b1;
        bad = 0;
        repeat (100 * DIV) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_en !== 1'b0) bad++;
        end
        chk("reset_idle", bad, 0);

        chk("crc_model", {16'd0, crc_check_string()}, 32'h0000_4B37);

        make_frame(8'h00, ADDR, 2); add_crc(1'b0); send_frame(-1, -1, 0);
        make_reply(); expect_reply("echo2");

        make_frame(8'h00, ADDR, 1); fr[3] = 8'h11; add_crc(1'b1); send_frame(-1, -1, 0);
        expect_none("bad_crc");
        make_frame(8'h00, 8'h12, 1); fr[3] = 8'h11; add_crc(1'b0); send_frame(-1, -1, 0);
        expect_none("wrong_addr");
        make_frame(8'h00, 8'hFF, 1); fr[3] = 8'h11; add_crc(1'b0); send_frame(-1, -1, 0);
        expect_none("broadcast");

        make_frame(8'h01, ADDR, 0); add_crc(1'b0); send_frame(-1, -1, 0);
        make_reply(); expect_reply("zero_len");
        make_frame(8'h05, ADDR, 16); add_crc(1'b0); send_frame(-1, -1, 0);
        make_reply(); expect_reply("max_len");
        make_frame(8'h06, ADDR, 17); add_crc(1'b0); send_frame(-1, -1, 0);
        expect_none("over_len");

        make_frame(8'h02, ADDR, 3); add_crc(1'b0); send_frame(3, -1, 0);
        expect_none("framing");
        make_frame(8'h08, ADDR, 1); add_crc(1'b0); send_frame(-1, -1, 0);
        make_reply(); expect_reply("after_framing");

        make_frame(8'h03, ADDR, 2); add_crc(1'b0); send_frame(-1, 2, 12);
        expect_none("timeout");
        make_frame(8'h09, ADDR, 2); add_crc(1'b0); send_frame(-1, -1, 0);
        make_reply(); expect_reply("after_timeout");

        rx = 1'b0;
        repeat (DIV / 4) @(negedge clk);
        rx = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        make_frame(8'h0A, ADDR, 1); add_crc(1'b0); send_frame(-1, -1, 0);
        make_reply(); expect_reply("after_glitch");

        make_frame(8'h07, ADDR, 3); add_crc(1'b0); send_frame(-1, -1, 0);
        got = 1'b0;
        for (int i = 0; i < 20 * DIV; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                got = 1'b1;
                break;
            end
        end
        chk("mid_reply_start", {31'd0, got}, 32'd1);
        @(negedge clk);
        #2 reset_n_i = 1'b0;
        #1;
        chk("async_rst_tx", {31'd0, tx}, 32'd1);
        chk("async_rst_txen", {31'd0, tx_en}, 32'd0);
        @(negedge clk);
        reset_n_i = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        make_frame(8'h0B, ADDR, 2); add_crc(1'b0); send_frame(-1, -1, 0);
        make_reply(); expect_reply("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
